// File: rtl/branch_resolve_ctrl_if.sv
// Signal bundle between the fetch/execute pipeline and the branch resolve controller.
interface branch_resolve_ctrl_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        stall;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        q_full;
  logic        q_empty;
  logic [15:0] mispredict_cnt;
  logic        underflow_err;

  // Pipeline side: drives fetch/execute information, observes resolution results.
  modport master (
    output if_valid, if_pc, bp_taken, bp_target, stall,
           ex_valid, ex_is_branch, ex_taken, ex_target,
    input  redirect, redirect_pc, flush, upd_en, upd_pc, upd_target, upd_taken,
           q_full, q_empty, mispredict_cnt, underflow_err
  );

  // Controller side.
  modport slave (
    input  if_valid, if_pc, bp_taken, bp_target, stall,
           ex_valid, ex_is_branch, ex_taken, ex_target,
    output redirect, redirect_pc, flush, upd_en, upd_pc, upd_target, upd_taken,
           q_full, q_empty, mispredict_cnt, underflow_err
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: queues predictions made at fetch, compares them
// against execute outcomes, issues redirect/flush on mispredict and trains the
// predictor on every resolved branch.
module branch_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [FW-1:0]   flush_cnt_reg, flush_cnt_next;

  // Prediction queue storage (small; read asynchronously at the head).
  logic [31:0]     pc_mem     [DEPTH];
  logic            taken_mem  [DEPTH];
  logic [31:0]     target_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic            redirect_reg, upd_en_reg, upd_taken_reg, underflow_reg;
  logic [31:0]     redirect_pc_reg, upd_pc_reg, upd_target_reg;
  logic [15:0]     mispredict_cnt_reg, mispredict_cnt_next;

  logic            q_full, q_empty, in_run, push, pop, mispredict, underflow_hit;
  logic [31:0]     head_pc, head_target, correct_pc;
  logic            head_taken;

  // Queue status, push/pop qualification and mispredict detection at the head.
  always_comb begin
    q_full        = (count_reg == CW'(DEPTH));
    q_empty       = (count_reg == '0);
    in_run        = (state_reg == RUN);
    pop           = in_run & bus.ex_valid & ~bus.stall & ~q_empty;
    push          = in_run & bus.if_valid & ~bus.stall & (~q_full | pop);
    underflow_hit = in_run & bus.ex_valid & ~bus.stall & q_empty;
    head_pc       = pc_mem[rd_ptr_reg];
    head_taken    = taken_mem[rd_ptr_reg];
    head_target   = target_mem[rd_ptr_reg];
    if (bus.ex_is_branch)
      mispredict = pop & ((head_taken != bus.ex_taken) |
                          (head_taken & bus.ex_taken & (head_target != bus.ex_target)));
    else
      mispredict = pop & head_taken;
    correct_pc = (bus.ex_is_branch & bus.ex_taken) ? bus.ex_target : head_pc + 32'd4;
    mispredict_cnt_next = mispredict_cnt_reg;
    if (mispredict && mispredict_cnt_reg != 16'hFFFF)
      mispredict_cnt_next = mispredict_cnt_reg + 16'd1;
  end

  // Next state: enter FLUSH on a mispredict, leave after FLUSH_CYCLES cycles.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      RUN: begin
        if (mispredict) begin
          state_next     = FLUSH;
          flush_cnt_next = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_reg == FW'(FLUSH_CYCLES - 1))
          state_next = RUN;
        else
          flush_cnt_next = flush_cnt_reg + FW'(1);
      end
      default: state_next = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Queue pointers and occupancy; a mispredict discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  // Queue storage write.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]     <= bus.if_pc;
      taken_mem[wr_ptr_reg]  <= bus.bp_taken;
      target_mem[wr_ptr_reg] <= bus.bp_target;
    end
  end

  // Registered resolution outputs: redirect, predictor update, statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_reg       <= 1'b0;
      redirect_pc_reg    <= '0;
      upd_en_reg         <= 1'b0;
      upd_pc_reg         <= '0;
      upd_target_reg     <= '0;
      upd_taken_reg      <= 1'b0;
      mispredict_cnt_reg <= '0;
      underflow_reg      <= 1'b0;
    end else begin
      redirect_reg       <= mispredict;
      if (mispredict) redirect_pc_reg <= correct_pc;
      upd_en_reg         <= pop & bus.ex_is_branch;
      if (pop && bus.ex_is_branch) begin
        upd_pc_reg     <= head_pc;
        upd_target_reg <= bus.ex_target;
        upd_taken_reg  <= bus.ex_taken;
      end
      mispredict_cnt_reg <= mispredict_cnt_next;
      if (underflow_hit) underflow_reg <= 1'b1;
    end
  end

  assign bus.redirect       = redirect_reg;
  assign bus.redirect_pc    = redirect_pc_reg;
  assign bus.flush          = (state_reg == FLUSH);
  assign bus.upd_en         = upd_en_reg;
  assign bus.upd_pc         = upd_pc_reg;
  assign bus.upd_target     = upd_target_reg;
  assign bus.upd_taken      = upd_taken_reg;
  assign bus.q_full         = q_full;
  assign bus.q_empty        = q_empty;
  assign bus.mispredict_cnt = mispredict_cnt_reg;
  assign bus.underflow_err  = underflow_reg;
endmodule
